// File: rtl/arm_control_unit_pkg.sv
// Shared definitions for the ARM-subset control unit: sequencer states,
// instruction field encodings, ALU/immediate selects and condition evaluation.
package arm_ctrl_pkg;

    // Sequencer states: one-cycle execution, or stalled on a data-memory access
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } seq_state_t;

    // Instr[27:26] op classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing cmd field (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ImmSrc encodings
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // Evaluate a condition field against an {N,Z,C,V} flag vector
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = ~z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = ~c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = ~n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = ~v;
            COND_HI: cond_holds = c & ~z;
            COND_LS: cond_holds = ~c | z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = ~z & (n == v);
            COND_LE: cond_holds = z | (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_control_unit_if.sv
// Data-memory request/acknowledge port between the control unit and memory.
interface arm_control_unit_if;
    import arm_ctrl_pkg::*;

    logic mem_req;
    logic MemWrite;
    logic mem_ack;

    // Control unit side: issues the access, waits for ack
    modport master (
        output mem_req,
        output MemWrite,
        input  mem_ack
    );

    // Memory side: sees the access, answers with ack
    modport slave (
        input  mem_req,
        input  MemWrite,
        output mem_ack
    );

endinterface

// File: rtl/arm_control_unit_cond_logic.sv
// NZCV flag register, condition evaluation and flag write enables.
module arm_cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] ALUFlags,
    input  logic       flag_nz_req,
    input  logic       flag_cv_req,
    input  logic       PCWrite,
    output logic       CondEx,
    output logic [3:0] flags_q
);

    logic [3:0] flag_we;

    // Condition is always judged against the stored flags, never the live ALU ones
    always_comb begin
        CondEx = cond_holds(cond, flags_q);
    end

    // NZ and CV groups load only for an executed, non-stalled flag-setting instruction
    always_comb begin
        flag_we      = 4'b0000;
        flag_we[3:2] = {2{flag_nz_req & CondEx & PCWrite}};
        flag_we[1:0] = {2{flag_cv_req & CondEx & PCWrite}};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_flag
            logic bit_reg;

            // One flag bit, loaded from the ALU when its group is enabled
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bit_reg <= 1'b0;
                end else if (flag_we[gi]) begin
                    bit_reg <= ALUFlags[gi];
                end
            end

            assign flags_q[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM-subset datapath: instruction decode,
// conditional write gating and a RUN/MEM_WAIT sequencer that stalls the PC
// while a data-memory access waits for its acknowledge.
module arm_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int TW          = 4    // 2**TW must exceed ACK_TIMEOUT
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        Instr,
    input  logic [3:0]         ALUFlags,
    arm_control_unit_if.master mem,
    output logic [1:0]         RegSrc,
    output logic               RegWrite,
    output logic [1:0]         ImmSrc,
    output logic               ALUSrc,
    output logic [1:0]         ALUControl,
    output logic               MemtoReg,
    output logic               PCSrc,
    output logic               PCWrite,
    output logic               mem_err,
    output logic [3:0]         flags_q
);

    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(ACK_TIMEOUT);

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;

    // Raw (ungated) decode results
    logic reg_write_raw;
    logic mem_write_raw;
    logic is_branch;
    logic is_mem;
    logic flag_nz_req;
    logic flag_cv_req;

    // Sequencer
    seq_state_t    state_reg, state_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic          mem_err_reg;
    logic          err_set;
    logic          cond_ex;
    logic          mem_req_seq;
    logic          mem_write_seq;
    logic          reg_write_seq;
    logic          pc_write_seq;
    logic          pc_src_seq;

    // Operand/shift fields are datapath business; only the decode bits are used here
    logic unused_fields;
    assign unused_fields = ^{Instr[19:16], Instr[11:0]};

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign rd    = Instr[15:12];

    // Decode op/funct into datapath selects and raw write requests
    always_comb begin
        RegSrc        = 2'b00;
        ImmSrc        = IMM_8;
        ALUSrc        = 1'b0;
        ALUControl    = ALU_ADD;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        is_branch     = 1'b0;
        is_mem        = 1'b0;
        flag_nz_req   = 1'b0;
        flag_cv_req   = 1'b0;
        case (op)
            OP_DP: begin
                ALUSrc = funct[5];
                case (cmd)
                    CMD_ADD: begin
                        ALUControl    = ALU_ADD;
                        reg_write_raw = 1'b1;
                        flag_nz_req   = funct[0];
                        flag_cv_req   = funct[0];
                    end
                    CMD_SUB: begin
                        ALUControl    = ALU_SUB;
                        reg_write_raw = 1'b1;
                        flag_nz_req   = funct[0];
                        flag_cv_req   = funct[0];
                    end
                    CMD_AND: begin
                        ALUControl    = ALU_AND;
                        reg_write_raw = 1'b1;
                        flag_nz_req   = funct[0];
                    end
                    CMD_ORR: begin
                        ALUControl    = ALU_ORR;
                        reg_write_raw = 1'b1;
                        flag_nz_req   = funct[0];
                    end
                    CMD_CMP: begin
                        // Compare only sets flags; S is implied
                        ALUControl  = ALU_SUB;
                        flag_nz_req = 1'b1;
                        flag_cv_req = 1'b1;
                    end
                    default: begin
                        // Unsupported cmd behaves as a NOP
                    end
                endcase
            end
            OP_MEM: begin
                is_mem        = 1'b1;
                ALUControl    = funct[3] ? ALU_ADD : ALU_SUB;
                ALUSrc        = 1'b1;
                ImmSrc        = IMM_12;
                RegSrc        = funct[0] ? 2'b00 : 2'b10;
                MemtoReg      = funct[0];
                reg_write_raw = funct[0];
                mem_write_raw = ~funct[0];
            end
            OP_BR: begin
                is_branch  = 1'b1;
                RegSrc     = 2'b01;
                ImmSrc     = IMM_24;
                ALUSrc     = 1'b1;
                ALUControl = ALU_ADD;
            end
            default: begin
                // Undefined class: all writes stay suppressed
            end
        endcase
    end

    arm_cond_logic u_cond_logic (
        .clk         (clk),
        .rst         (rst),
        .cond        (cond),
        .ALUFlags    (ALUFlags),
        .flag_nz_req (flag_nz_req),
        .flag_cv_req (flag_cv_req),
        .PCWrite     (PCWrite),
        .CondEx      (cond_ex),
        .flags_q     (flags_q)
    );

    // Next-state and strobe generation for the memory-access sequencer
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        err_set       = 1'b0;
        mem_req_seq   = 1'b0;
        mem_write_seq = 1'b0;
        pc_write_seq  = 1'b1;
        reg_write_seq = cond_ex & reg_write_raw;
        pc_src_seq    = cond_ex & (is_branch | (reg_write_raw & (rd == 4'd15)));
        case (state_reg)
            RUN: begin
                if (is_mem && cond_ex) begin
                    mem_req_seq   = 1'b1;
                    mem_write_seq = mem_write_raw;
                    if (!mem.mem_ack) begin
                        // No same-cycle ack: stall and hold the request
                        state_next    = MEM_WAIT;
                        cnt_next      = '0;
                        pc_write_seq  = 1'b0;
                        reg_write_seq = 1'b0;
                        pc_src_seq    = 1'b0;
                    end
                end
            end
            MEM_WAIT: begin
                // The instruction was committed on entry, so raw strobes apply
                mem_req_seq   = 1'b1;
                mem_write_seq = mem_write_raw;
                reg_write_seq = reg_write_raw;
                pc_src_seq    = reg_write_raw & (rd == 4'd15);
                if (mem.mem_ack) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    // Abandon the access: skip the instruction, flag the error
                    state_next    = RUN;
                    cnt_next      = '0;
                    err_set       = 1'b1;
                    reg_write_seq = 1'b0;
                    pc_src_seq    = 1'b0;
                end else begin
                    cnt_next      = cnt_reg + 1'b1;
                    pc_write_seq  = 1'b0;
                    reg_write_seq = 1'b0;
                    pc_src_seq    = 1'b0;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Sequencer state, wait counter and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= RUN;
            cnt_reg     <= '0;
            mem_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mem_err_reg <= mem_err_reg | err_set;
        end
    end

    // Access and write strobes are held off for as long as reset is asserted
    assign mem.mem_req  = rst & mem_req_seq;
    assign mem.MemWrite = rst & mem_write_seq;
    assign RegWrite     = rst & reg_write_seq;
    assign PCWrite      = rst & pc_write_seq;
    assign PCSrc        = pc_src_seq;
    assign mem_err      = mem_err_reg;

endmodule

// File: tb/tb_arm_control_unit.sv
// Self-checking bench for arm_control_unit: directed cases plus random
// instruction streams checked against a behavioural model of the ISA rules.
module tb_arm_control_unit;

    localparam int ACK_TIMEOUT = 15;
    localparam int TW          = 4;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        PCSrc;
    logic        PCWrite;
    logic        mem_err;
    logic [3:0]  flags_q;

    arm_control_unit_if mif ();

    arm_control_unit #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TW          (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem        (mif),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .MemtoReg   (MemtoReg),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .mem_err    (mem_err),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: architectural flags and sticky error
    logic [3:0] flags_m = 4'b0000;
    logic       err_m   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (instr %08h)", tag, obs, exp, Instr);
        end
    endtask

    // Conditions come in complementary pairs; bit 0 of the code inverts the base test
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    typedef struct {
        bit         is_dp, is_mem, is_br, cmd_ok;
        bit         wr_reg, wr_mem, set_nz, set_cv;
        logic [1:0] reg_src, imm_src, alu_ctl;
        logic       alu_src, m2r;
    } dec_t;

    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t d;
        logic [3:0] cmd;
        cmd = ins[24:21];
        d = '{default: 0};
        case (ins[27:26])
            2'b00: begin
                d.is_dp = 1; d.reg_src = 2'b00; d.imm_src = 2'b00; d.alu_src = ins[25]; d.m2r = 0;
                d.cmd_ok = 1;
                if (cmd == 4'b0100)      begin d.alu_ctl = 2'b00; d.wr_reg = 1; d.set_nz = ins[20]; d.set_cv = ins[20]; end
                else if (cmd == 4'b0010) begin d.alu_ctl = 2'b01; d.wr_reg = 1; d.set_nz = ins[20]; d.set_cv = ins[20]; end
                else if (cmd == 4'b0000) begin d.alu_ctl = 2'b10; d.wr_reg = 1; d.set_nz = ins[20]; end
                else if (cmd == 4'b1100) begin d.alu_ctl = 2'b11; d.wr_reg = 1; d.set_nz = ins[20]; end
                else if (cmd == 4'b1010) begin d.alu_ctl = 2'b01; d.set_nz = 1; d.set_cv = 1; end
                else d.cmd_ok = 0;
            end
            2'b01: begin
                d.is_mem = 1; d.alu_ctl = ins[23] ? 2'b00 : 2'b01; d.alu_src = 1; d.imm_src = 2'b01;
                d.reg_src = ins[20] ? 2'b00 : 2'b10; d.m2r = ins[20];
                d.wr_reg = ins[20]; d.wr_mem = !ins[20];
            end
            2'b10: begin
                d.is_br = 1; d.reg_src = 2'b01; d.imm_src = 2'b10; d.alu_src = 1; d.alu_ctl = 2'b00;
            end
            default: ;
        endcase
        return d;
    endfunction

    task automatic check_ctl(input dec_t d);
        if (d.is_dp || d.is_mem || d.is_br) begin
            check("RegSrc", RegSrc, d.reg_src);
            check("ImmSrc", ImmSrc, d.imm_src);
            check("ALUSrc", ALUSrc, d.alu_src);
        end
        if (d.is_dp || d.is_mem) check("MemtoReg", MemtoReg, d.m2r);
        if ((d.is_dp && d.cmd_ok) || d.is_mem || d.is_br) check("ALUControl", ALUControl, d.alu_ctl);
        check("flags_q", flags_q, flags_m);
        check("mem_err", mem_err, err_m);
    endtask

    // Execute one instruction; ack_at = cycle index of mem_ack for LDR/STR, -1 = never
    task automatic exec(input logic [31:0] ins, input logic [3:0] alu_f, input int ack_at);
        dec_t d;
        bit   ce, done, tmo, to_pc;
        int   ncyc;
        d     = model_decode(ins);
        ce    = cond_pass(ins[31:28], flags_m);
        to_pc = (ins[15:12] == 4'd15);
        ncyc  = 0;
        Instr    = ins;
        ALUFlags = alu_f;
        if (d.is_mem && ce) begin
            for (int idx = 0; idx <= ACK_TIMEOUT + 1; idx++) begin
                done = (idx == ack_at);
                tmo  = !done && (idx == ACK_TIMEOUT + 1);
                mif.mem_ack = done;
                @(negedge clk);
                check_ctl(d);
                check("mem_req", mif.mem_req, 1'b1);
                check("PCWrite", PCWrite, done || tmo);
                check("RegWrite", RegWrite, done && d.wr_reg);
                check("PCSrc", PCSrc, done && d.wr_reg && to_pc);
                if (!tmo) check("MemWrite", mif.MemWrite, d.wr_mem);
                @(posedge clk);
                #1;
                ncyc++;
                if (tmo) err_m = 1'b1;
                if (done || tmo) break;
            end
        end else begin
            mif.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_ctl(d);
            check("mem_req", mif.mem_req, 1'b0);
            check("PCWrite", PCWrite, 1'b1);
            check("RegWrite", RegWrite, ce && d.wr_reg);
            check("MemWrite", mif.MemWrite, 1'b0);
            check("PCSrc", PCSrc, ce && (d.is_br || (d.wr_reg && to_pc)));
            @(posedge clk);
            #1;
            ncyc = 1;
            if (ce && d.set_nz) flags_m[3:2] = alu_f[3:2];
            if (ce && d.set_cv) flags_m[1:0] = alu_f[1:0];
        end
        mif.mem_ack = 1'b0;
        $display("txn instr=%08h aluflags=%b cond_ex=%0d cycles=%0d flags_model=%b", ins, alu_f, ce, ncyc, flags_m);
    endtask

    logic [3:0] cmd_tab [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

    initial begin
        logic [31:0] ins;
        int          a, ack_at;

        // Reset with an instruction present: strobes low, selects follow Instr
        rst         = 1'b0;
        Instr       = 32'hE2921005;
        ALUFlags    = 4'b1111;
        mif.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_PCWrite", PCWrite, 1'b0);
        check("rst_mem_req", mif.mem_req, 1'b0);
        check("rst_MemWrite", mif.MemWrite, 1'b0);
        check("rst_flags_q", flags_q, 4'b0000);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_ALUSrc", ALUSrc, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed sequence
        exec(32'hE2921005, 4'b0000, 0);    // ADDS R1,R2,#5
        exec(32'hE280F000, 4'b0000, 0);    // ADD R15,R0,#0 -> PCSrc
        exec(32'h0280F000, 4'b0000, 0);    // same, EQ with Z=0 -> no strobes
        exec(32'hE1510001, 4'b0100, 0);    // CMP R1,R1 -> Z
        exec(32'h0A000002, 4'b0000, 0);    // BEQ taken
        exec(32'h1A000002, 4'b0000, 0);    // BNE not taken
        exec(32'hE5903004, 4'b0000, 3);    // LDR, ack on 4th cycle
        exec(32'hE5801000, 4'b0000, 0);    // STR, same-cycle ack
        exec(32'hE5801000, 4'b0000, -1);   // STR, timeout
        exec(32'hE1A00000, 4'b0000, 0);    // back in RUN, error sticky
        exec(32'hE1510001, 4'b1010, 0);    // CMP sets N and C

        // Reset in the middle of a wait
        Instr = 32'hE5903004;
        mif.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_mem_req", mif.mem_req, 1'b1);
            check("wait_PCWrite", PCWrite, 1'b0);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check("abort_mem_req", mif.mem_req, 1'b0);
        check("abort_RegWrite", RegWrite, 1'b0);
        check("abort_PCWrite", PCWrite, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        flags_m = 4'b0000;
        err_m   = 1'b0;
        $display("txn reset during MEM_WAIT");
        exec(32'hE1A00000, 4'b0000, 0);

        // Random instruction stream
        for (int n = 0; n < 200; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) != 0) ins[31:28] = 4'hE;
            if (ins[27:26] == 2'b00 && $urandom_range(0, 3) != 0) ins[24:21] = cmd_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
            a = $urandom_range(0, 9);
            ack_at = (a == 9) ? -1 : (a % 5);
            exec(ins, 4'($urandom), ack_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
